dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Optional feature macro: DMEM_ERR_CHECK_EN (address fault checking).
package dmem_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Default parameter values
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_WAIT_CYCLES = 1;

  // Largest supported number of wait states and the counter width covering it
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one byte-enabled write port, two asynchronous
// read ports (one for the access path, one for debug visibility).
// Contents are intentionally not reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-granular write: only lanes with their enable set are updated
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one CPU access at a time, inserts
// WAIT_CYCLES wait states, then completes with a one-cycle rsp_valid pulse.
// Optional feature macro: DMEM_ERR_CHECK_EN -- when defined, misaligned or
// out-of-range byte addresses complete with rsp_err=1, rdata=0 and no write.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so the CPU holds req_valid (and the request
// fields) until it sees req_ready. rsp_valid is high for exactly the one RESP
// cycle, with rsp_rdata/rsp_err valid alongside it; there is no rsp back-pressure.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [1:0]            dbg_state
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF    = $clog2(BE_W);
  localparam int IDX_HI = ADDR_W + OFF - 1;
  // Counter value on the last wait cycle (unused when WAIT_CYCLES is 0)
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                enter_resp;

  // Registered request fields
  logic                acc_we;
  logic [31:0]         acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;

  // Fields of the access being completed on this edge. With zero wait states
  // RESP is entered on the acceptance edge itself, before the registers hold
  // the request, so the live request is used while in IDLE.
  logic                cur_we;
  logic [31:0]         cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BE_W-1:0]     cur_be;
  logic [ADDR_W-1:0]   cur_idx;
  logic                cur_err;

  logic                mem_we;
  logic [DATA_W-1:0]   arr_rdata;
  logic [DATA_W-1:0]   rdata_q;

  assign accept = req_valid && req_ready;

  assign cur_we    = (state == IDLE) ? req_we    : acc_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : acc_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : acc_wdata;
  assign cur_be    = (state == IDLE) ? req_be    : acc_be;
  assign cur_idx   = cur_addr[IDX_HI:OFF];

`ifdef DMEM_ERR_CHECK_EN
  assign cur_err = (cur_addr[OFF-1:0] != '0) || (cur_addr[31:IDX_HI+1] != '0);
`else
  // Low and high address bits are ignored: the index wraps modulo the depth
  assign cur_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[OFF-1:0], cur_addr[31:IDX_HI+1]};
`endif

  // RESP is only ever entered from IDLE or WAIT
  assign enter_resp = (next_state == RESP) && (state != RESP);

  // Reset gates the write so an access aborted by reset never commits
  assign mem_we = rstn && enter_resp && cur_we && !cur_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (cur_idx),
    .wdata    (cur_wdata),
    .be       (cur_be),
    .raddr    (cur_idx),
    .rdata    (arr_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == WAIT_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    dbg_state = state;
  end

  // Wait-state counter: cleared on acceptance, advanced in WAIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture the request fields on acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_be    <= '0;
    end else if (accept) begin
      acc_we    <= req_we;
      acc_addr  <= req_addr;
      acc_wdata <= req_wdata;
      acc_be    <= req_be;
    end
  end

  // Response data sampled on the edge entering RESP; writes and faults return 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (enter_resp) begin
      rdata_q <= (cur_we || cur_err) ? '0 : arr_rdata;
    end
  end

  assign rsp_rdata = rdata_q;

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;

  // Fault flag sampled alongside the response data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= cur_err;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Main instance uses WAIT_CYCLES=1;
// a second instance with WAIT_CYCLES=0 exercises back-to-back throughput.
// Honours DMEM_ERR_CHECK_EN for the address-fault / aliasing cases.
module tb_dmem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (WAIT_CYCLES=1) ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  dbg_addr  = '0;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(7), .WAIT_CYCLES(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---------------- second DUT (WAIT_CYCLES=0) ----------------
  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we    = 1'b1;
  logic [31:0] z_req_addr  = 32'h0000_0040;
  logic [31:0] z_req_wdata = 32'h0BAD_CAFE;
  logic [3:0]  z_req_be    = 4'hF;
  logic        z_rsp_valid;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;
  logic [6:0]  z_dbg_addr  = '0;
  logic [31:0] z_dbg_data;
  logic [1:0]  z_dbg_state;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(7), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_be    (z_req_be),
    .rsp_valid (z_rsp_valid),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err),
    .dbg_addr  (z_dbg_addr),
    .dbg_data  (z_dbg_data),
    .dbg_state (z_dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          acc_cyc_q[$];

  localparam int EXP_LAT = 2;  // WAIT_CYCLES + 1, counted from the handshake cycle

  // Every rsp_valid cycle must match a pending access
  always @(negedge clk) begin
    if (rsp_valid) begin
      check("ready_in_resp", req_ready, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        logic [31:0] e;
        logic        ee;
        int          ac;
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        ac = acc_cyc_q.pop_front();
        check("rsp_rdata", rsp_rdata, e);
        check("rsp_err", rsp_err, ee);
        check("latency", cyc - ac, EXP_LAT);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl [128];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata,
                           input logic exp_err);
    int n;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 1'b1, 1'b0);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    acc_cyc_q.push_back(cyc);
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_in_wait", req_ready, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_err_q.delete();
      acc_cyc_q.delete();
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    do_access(1'b1, addr, wdata, be, 32'h0, 1'b0);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] exp);
    do_access(1'b0, addr, 32'h0, 4'h0, exp, 1'b0);
  endtask

  task automatic check_dbg(input string tag, input logic [6:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int accepts;
    int pulses;
    logic [6:0]  idx;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  be;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_ready_z", z_req_ready, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    // Full-word write then read
    write_word(32'h10, 32'h1234_5678, 4'hF);
    read_word(32'h10, 32'h1234_5678);

    // Partial byte-enable write
    write_word(32'h10, 32'hAABB_CCDD, 4'b0101);
    read_word(32'h10, 32'h12BB_56DD);
    check_dbg("dbg_word4", 7'd4, 32'h12BB_56DD);

    // Zero byte enables leave the word unchanged
    write_word(32'h10, 32'hFFFF_FFFF, 4'h0);
    read_word(32'h10, 32'h12BB_56DD);

    // Random words: full write, random partial write, read back
    for (int i = 0; i < 6; i++) begin
      idx = 7'($urandom_range(0, 127));
      d0  = $urandom;
      d1  = $urandom;
      be  = 4'($urandom_range(0, 15));
      write_word({23'h0, idx, 2'b00}, d0, 4'hF);
      mdl[idx] = d0;
      write_word({23'h0, idx, 2'b00}, d1, be);
      mdl[idx] = merge(mdl[idx], d1, be);
      read_word({23'h0, idx, 2'b00}, mdl[idx]);
      check_dbg("dbg_rand", idx, mdl[idx]);
    end

`ifdef DMEM_ERR_CHECK_EN
    // Faulting accesses: error flag, zero data, memory untouched
    write_word(32'h10, 32'h1234_5678, 4'hF);
    write_word(32'h0, 32'h5555_AAAA, 4'hF);
    do_access(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    do_access(1'b1, 32'h1000, 32'hDEAD_DEAD, 4'hF, 32'h0, 1'b1);
    check_dbg("err_word4", 7'd4, 32'h1234_5678);
    check_dbg("err_word0", 7'd0, 32'h5555_AAAA);
`else
    // Address wraps modulo the depth: 0x210 aliases to word 4
    write_word(32'h210, 32'hCAFE_F00D, 4'hF);
    check_dbg("alias_word4", 7'd4, 32'hCAFE_F00D);
    read_word(32'h10, 32'hCAFE_F00D);
`endif

    // Reset during WAIT of a write aborts it
    write_word(32'h20, 32'h5A5A_5A5A, 4'hF);
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hDEAD_BEEF;
    req_be    = 4'hF;
    req_valid = 1'b1;
    check("pre_abort_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", dbg_state, 2'd1);
    #2 rstn = 1'b0;
    #1;
    check("abort_rst_state", dbg_state, 2'd0);
    check("abort_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);
    repeat (4) @(negedge clk);
    check_dbg("abort_word8", 7'd8, 32'h5A5A_5A5A);
    read_word(32'h20, 32'h5A5A_5A5A);

    // Back-to-back on the zero-wait instance: valid held 6 cycles
    accepts = 0;
    pulses  = 0;
    @(negedge clk);
    z_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) z_req_valid = 1'b0;
      if (z_req_valid && z_req_ready) accepts++;
      if (z_rsp_valid) begin
        pulses++;
        check("z_ready_in_resp", z_req_ready, 1'b0);
        check("z_rsp_rdata", z_rsp_rdata, 32'h0);
      end
      @(negedge clk);
    end
    check("z_accepts", 64'(accepts), 64'd3);
    check("z_pulses", 64'(pulses), 64'd3);
    z_dbg_addr = 7'd16;
    #1;
    check("z_word16", z_dbg_data, 32'h0BAD_CAFE);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
